// File: rtl/bitpair_scan_ctrl.sv
// Scan sequencer for an external two-equal-consecutive-bits detector: accepts a word, clears the
// detector, shifts the word in MSB-first and returns hit count, first-hit index and any-hit flag.
module bitpair_scan_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          det_rst,
  output logic          det_bit,
  input  logic          det_hit,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count,
  output logic [CW-1:0] res_first,
  output logic          res_hit,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [CW-1:0] LAST_IDX  = CW'(W - 1);
  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

  state_e        state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] first_q, first_d;
  logic          hit_q, hit_d;
  logic          det_rst_q, det_rst_d;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    count_d = count_q;
    first_d = first_q;
    hit_d   = hit_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = in_data;
          idx_d   = '0;
          count_d = '0;
          first_d = '0;
          hit_d   = 1'b0;
          state_d = CLR;
        end
      end
      CLR: state_d = SHIFT;
      SHIFT: begin
        sreg_d = {sreg_q[W-2:0], 1'b0};
        if (det_hit) begin
          if (count_q != COUNT_MAX) count_d = count_q + CW'(1);
          hit_d = 1'b1;
          if (!hit_q) first_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered from next state so the detector reset releases exactly as SHIFT begins.
    det_rst_d = (state_d != SHIFT);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      first_q   <= '0;
      hit_q     <= 1'b0;
      det_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      first_q   <= first_d;
      hit_q     <= hit_d;
      det_rst_q <= det_rst_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign det_bit   = (state_q == SHIFT) && sreg_q[W-1];
  assign det_rst   = det_rst_q;
  assign res_count = count_q;
  assign res_first = first_q;
  assign res_hit   = hit_q;

endmodule
